// File: rtl/spi_byte_engine_if.sv
// CPU-side bus bundle for the SPI byte engine: 6309 strobe, R/W, address and data.
interface spi_byte_engine_if;
  logic        nE;
  logic        RW;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        D_oe;

  modport master (output nE, RW, A, D_in, input D_out, D_oe);
  modport slave  (input nE, RW, A, D_in, output D_out, D_oe);
endinterface

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI master: a CPU write to DATA shifts one byte out MSB first and
// captures the simultaneous MISO byte for readback; STATUS holds busy/ovr/fast.
module spi_byte_engine #(
  parameter logic [15:0] BASE_ADDR = 16'hFE32,
  parameter int unsigned DIV_FAST  = 4,
  parameter int unsigned DIV_SLOW  = 60
) (
  input  logic               MHZ48,
  input  logic               nRES,
  spi_byte_engine_if.slave   bus,
  input  logic               MISO,
  output logic               sclk,
  output logic               mosi,
  output logic               busy
);

  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} state_t;

  state_t      state_q, state_d;
  logic [15:0] hc_q, hc_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        fast_q, fast_d;
  logic        ovr_q, ovr_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        ne_prev_q, ne_prev_d;
  logic [15:0] a_q, a_d;
  logic        rw_q, rw_d;
  logic [7:0]  din_q, din_d;

  logic        strobe;
  logic        data_wr;
  logic        status_wr;
  logic        status_rd;
  logic        done;
  logic [15:0] div_m1;

  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    fast_d    = fast_q;
    ovr_d     = ovr_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    ne_prev_d = bus.nE;
    a_d       = a_q;
    rw_d      = rw_q;
    din_d     = din_q;
    done      = 1'b0;

    if (!bus.nE) begin
      a_d   = bus.A;
      rw_d  = bus.RW;
      din_d = bus.D_in;
    end

    // One strobe per bus cycle: the first edge after nE returns high.
    strobe    = bus.nE & ~ne_prev_q;
    data_wr   = strobe & ~rw_q & (a_q == BASE_ADDR);
    status_wr = strobe & ~rw_q & (a_q == STATUS_ADDR);
    status_rd = strobe &  rw_q & (a_q == STATUS_ADDR);
    div_m1    = fast_q ? 16'(DIV_FAST - 1) : 16'(DIV_SLOW - 1);

    if (status_wr) fast_d = din_q[0];
    if (status_rd) ovr_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
      end
      ST_LOW: begin
        if (hc_q == '0) begin
          sclk_d   = 1'b1;
          shift_d  = {shift_q[6:0], MISO};
          bitcnt_d = bitcnt_q + 4'd1;
          hc_d     = div_m1;
          state_d  = ST_HIGH;
        end else begin
          hc_d = hc_q - 16'd1;
        end
      end
      ST_HIGH: begin
        if (hc_q == '0) begin
          sclk_d = 1'b0;
          if (bitcnt_q == 4'd8) begin
            rx_d    = shift_q;
            busy_d  = 1'b0;
            mosi_d  = 1'b1;
            state_d = ST_IDLE;
            done    = 1'b1;
          end else begin
            mosi_d  = shift_q[7];
            hc_d    = div_m1;
            state_d = ST_LOW;
          end
        end else begin
          hc_d = hc_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write landing on the finishing edge starts the next byte with no idle gap;
    // the overrun set is applied after the read-clear so it wins a collision.
    if (data_wr) begin
      if ((state_q == ST_IDLE) || done) begin
        shift_d  = din_q;
        mosi_d   = din_q[7];
        busy_d   = 1'b1;
        bitcnt_d = '0;
        hc_d     = div_m1;
        state_d  = ST_LOW;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge MHZ48) begin
    if (!nRES) begin
      state_q   <= ST_IDLE;
      hc_q      <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      rx_q      <= '1;
      fast_q    <= 1'b0;
      ovr_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      busy_q    <= 1'b0;
      ne_prev_q <= 1'b1;
      a_q       <= '0;
      rw_q      <= 1'b1;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      fast_q    <= fast_d;
      ovr_q     <= ovr_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      ne_prev_q <= ne_prev_d;
      a_q       <= a_d;
      rw_q      <= rw_d;
      din_q     <= din_d;
    end
  end

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign busy = busy_q;

  always_comb begin
    bus.D_oe  = ~bus.nE & bus.RW & ((bus.A == BASE_ADDR) | (bus.A == STATUS_ADDR));
    bus.D_out = (bus.A == STATUS_ADDR) ? {busy_q, 5'b0, ovr_q, fast_q} : rx_q;
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Randomized self-checking bench for spi_byte_engine with a mode-0 slave model.
module tb_spi_byte_engine;
  localparam logic [15:0] DATA_A = 16'hFE32;
  localparam logic [15:0] STAT_A = 16'hFE33;
  localparam int unsigned DF = 4;
  localparam int unsigned DS = 60;

  logic MHZ48 = 1'b0;
  logic nRES  = 1'b0;
  logic MISO;
  logic sclk, mosi, busy;

  spi_byte_engine_if bus();

  spi_byte_engine #(.BASE_ADDR(16'hFE32), .DIV_FAST(DF), .DIV_SLOW(DS)) dut (
    .MHZ48(MHZ48), .nRES(nRES), .bus(bus), .MISO(MISO),
    .sclk(sclk), .mosi(mosi), .busy(busy)
  );

  always #5 MHZ48 = ~MHZ48;

  int unsigned cyc = 0;
  always @(posedge MHZ48) cyc <= cyc + 1;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Observe every sclk rising edge: the MOSI bit presented and the edge number.
  logic        sclk_prev = 1'b0;
  int unsigned rise_total = 0;
  int unsigned rise_base = 0;
  logic        rise_mosi[$];
  int unsigned rise_cyc[$];
  logic [7:0]  slave_pat = 8'hFF;

  always @(negedge MHZ48) begin
    if (sclk && !sclk_prev) begin
      rise_mosi.push_back(mosi);
      rise_cyc.push_back(cyc);
      rise_total = rise_total + 1;
    end
    sclk_prev = sclk;
  end

  function automatic logic miso_bit(input logic [7:0] p, input int unsigned n);
    if (n >= 8) return 1'b1;
    return p[7-n];
  endfunction

  assign MISO = miso_bit(slave_pat, rise_total - rise_base);

  // Caller is at a negedge; returns at the negedge after the strobe edge (s = strobe edge).
  task automatic bus_cycle(input logic rw, input logic [15:0] a, input logic [7:0] d,
                           output logic [7:0] rdata, output logic oe, output int unsigned s);
    bus.nE = 1'b0; bus.RW = rw; bus.A = a; bus.D_in = d;
    #1;
    rdata = bus.D_out;
    oe    = bus.D_oe;
    @(negedge MHZ48);
    bus.nE = 1'b1;
    @(negedge MHZ48);
    s = cyc;
    bus.RW = 1'b1;
  endtask

  task automatic start_tx(input logic [7:0] tx, input logic [7:0] pat, output int unsigned s);
    logic [7:0] r; logic oe;
    slave_pat = pat;
    rise_base = rise_total;
    rise_mosi.delete();
    rise_cyc.delete();
    bus_cycle(1'b0, DATA_A, tx, r, oe, s);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL busy_set got %b want 1", busy); else n_pass++;
  endtask

  task automatic finish_tx(input logic [7:0] tx, input logic [7:0] pat, input int unsigned div,
                           input int unsigned s, input string name);
    logic [7:0] r; logic oe; int unsigned sd;
    while (busy === 1'b1 && cyc < s + 16*div + 50) @(negedge MHZ48);
    n_chk++;
    if (cyc !== s + 16*div)
      $display("FAIL %s byte_time got %0d want %0d", name, cyc - s, 16*div);
    else n_pass++;
    n_chk++;
    if (rise_mosi.size() !== 8)
      $display("FAIL %s rise_count got %0d want 8", name, rise_mosi.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (rise_mosi[i] !== tx[7-i] || rise_cyc[i] !== s + div*(2*i+1))
          $display("FAIL %s bit%0d mosi=%b at %0d want %b at %0d", name, i,
                   rise_mosi[i], rise_cyc[i] - s, tx[7-i], div*(2*i+1));
        else n_pass++;
      end
    end
    bus_cycle(1'b1, DATA_A, 8'h00, r, oe, sd);
    n_chk++;
    if (r !== pat || oe !== 1'b1) $display("FAIL %s rx got %h oe %b want %h", name, r, oe, pat);
    else n_pass++;
    n_chk++;
    if (sclk !== 1'b0 || mosi !== 1'b1) $display("FAIL %s idle sclk=%b mosi=%b want 0 1", name, sclk, mosi);
    else n_pass++;
  endtask

  task automatic write_status(input logic [7:0] v);
    logic [7:0] r; logic oe; int unsigned s;
    bus_cycle(1'b0, STAT_A, v, r, oe, s);
  endtask

  task automatic test_reset;
    logic [7:0] r; logic oe; int unsigned s;
    bus_cycle(1'b1, STAT_A, 8'h00, r, oe, s);
    n_chk++;
    if (r !== 8'h00 || oe !== 1'b1) $display("FAIL reset_status got %h oe %b want 00 1", r, oe); else n_pass++;
    bus_cycle(1'b1, DATA_A, 8'h00, r, oe, s);
    n_chk++;
    if (r !== 8'hFF) $display("FAIL reset_data got %h want ff", r); else n_pass++;
    n_chk++;
    if (sclk !== 1'b0 || mosi !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_pins sclk=%b mosi=%b busy=%b want 0 1 0", sclk, mosi, busy);
    else n_pass++;
  endtask

  task automatic test_fast;
    int unsigned s; logic [7:0] tx, pat;
    write_status(8'h01);
    start_tx(8'hA5, 8'h3C, s);
    finish_tx(8'hA5, 8'h3C, DF, s, "fast_a5");
    for (int k = 0; k < 4; k++) begin
      tx  = 8'($urandom);
      pat = 8'($urandom);
      start_tx(tx, pat, s);
      finish_tx(tx, pat, DF, s, "fast_rand");
    end
  endtask

  task automatic test_overrun;
    int unsigned s, s2; logic [7:0] r, tx, pat; logic oe;
    tx  = 8'($urandom);
    pat = 8'($urandom);
    start_tx(tx, pat, s);
    repeat (10) @(negedge MHZ48);
    bus_cycle(1'b0, DATA_A, 8'hFF, r, oe, s2);
    finish_tx(tx, pat, DF, s, "overrun_stream");
    bus_cycle(1'b1, STAT_A, 8'h00, r, oe, s2);
    n_chk++;
    if (r !== 8'h03) $display("FAIL ovr_set got %h want 03", r); else n_pass++;
    bus_cycle(1'b1, STAT_A, 8'h00, r, oe, s2);
    n_chk++;
    if (r !== 8'h01) $display("FAIL ovr_clear got %h want 01", r); else n_pass++;
  endtask

  task automatic test_slow;
    int unsigned s;
    write_status(8'h00);
    start_tx(8'h00, 8'hFF, s);
    finish_tx(8'h00, 8'hFF, DS, s, "slow");
  endtask

  task automatic test_reset_mid;
    int unsigned s; logic [7:0] r, tx, pat; logic oe;
    write_status(8'h01);
    start_tx(8'h5A, 8'hC3, s);
    while (rise_mosi.size() < 4 && cyc < s + 200) @(negedge MHZ48);
    n_chk++;
    if (rise_mosi.size() !== 4) $display("FAIL mid_reach got %0d want 4", rise_mosi.size()); else n_pass++;
    nRES = 1'b0;
    @(negedge MHZ48);
    n_chk++;
    if (sclk !== 1'b0 || busy !== 1'b0 || mosi !== 1'b1)
      $display("FAIL mid_reset sclk=%b busy=%b mosi=%b want 0 0 1", sclk, busy, mosi);
    else n_pass++;
    nRES = 1'b1;
    bus_cycle(1'b1, DATA_A, 8'h00, r, oe, s);
    n_chk++;
    if (r !== 8'hFF) $display("FAIL mid_rx got %h want ff", r); else n_pass++;
    bus_cycle(1'b1, STAT_A, 8'h00, r, oe, s);
    n_chk++;
    if (r !== 8'h00) $display("FAIL mid_status got %h want 00", r); else n_pass++;
    write_status(8'h01);
    tx  = 8'($urandom);
    pat = 8'($urandom);
    start_tx(tx, pat, s);
    finish_tx(tx, pat, DF, s, "after_reset");
  endtask

  task automatic test_back_to_back;
    int unsigned s1, s2, sd; logic [7:0] r, tx1, tx2, p1, p2; logic oe;
    tx1 = 8'($urandom); p1 = 8'($urandom);
    tx2 = 8'($urandom); p2 = 8'($urandom);
    start_tx(tx1, p1, s1);
    while (cyc < s1 + 16*DF - 2) @(negedge MHZ48);
    n_chk++;
    if (rise_mosi.size() !== 8) $display("FAIL b2b_first_rises got %0d want 8", rise_mosi.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (rise_mosi[i] !== tx1[7-i]) $display("FAIL b2b_first_bit%0d got %b want %b", i, rise_mosi[i], tx1[7-i]);
        else n_pass++;
      end
    end
    start_tx(tx2, p2, s2);
    n_chk++;
    if (s2 !== s1 + 16*DF) $display("FAIL b2b_strobe got %0d want %0d", s2 - s1, 16*DF); else n_pass++;
    bus_cycle(1'b1, DATA_A, 8'h00, r, oe, sd);
    n_chk++;
    if (r !== p1 || busy !== 1'b1) $display("FAIL b2b_rx1 got %h busy %b want %h 1", r, busy, p1); else n_pass++;
    finish_tx(tx2, p2, DF, s2, "b2b_second");
    bus_cycle(1'b1, STAT_A, 8'h00, r, oe, sd);
    n_chk++;
    if (r !== 8'h01) $display("FAIL b2b_no_ovr got %h want 01", r); else n_pass++;
    bus_cycle(1'b1, 16'hFE34, 8'h00, r, oe, sd);
    n_chk++;
    if (oe !== 1'b0) $display("FAIL oe_other_addr got %b want 0", oe); else n_pass++;
  endtask

  initial begin
    bus.nE = 1'b1; bus.RW = 1'b1; bus.A = '0; bus.D_in = '0;
    repeat (4) @(negedge MHZ48);
    nRES = 1'b1;
    @(negedge MHZ48);
    test_reset;
    test_fast;
    test_overrun;
    test_slow;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
